// File: rtl/gte_cop2_sequencer.sv
// gte_cop2_sequencer
// Takes COP2 register writes/reads and execute commands from the CPU one at a
// time and drives them onto the GTE engine's register and run ports. Every
// command is held off while the engine reports it is executing, so no register
// access ever overlaps an execution. CPU stall cycles are counted in a
// saturating counter.
module gte_cop2_sequencer #(
  parameter int STALL_W = 16
) (
  input  logic               i_clk,
  input  logic               i_rst,
  // CPU command side
  input  logic               i_cmdValid,
  output logic               o_cmdReady,
  input  logic [1:0]         i_cmdOp,
  input  logic [5:0]         i_cmdReg,
  input  logic [31:0]        i_cmdData,
  input  logic [24:0]        i_cmdInstr,
  output logic               o_rspValid,
  output logic [31:0]        o_rspData,
  output logic               o_cpuStall,
  output logic               o_errIllegal,
  input  logic               i_stallClr,
  output logic [STALL_W-1:0] o_stallCount,
  // GTE engine side
  output logic [5:0]         o_regID,
  output logic               o_writReg,
  output logic [31:0]        o_dataIn,
  input  logic [31:0]        i_dataOut,
  output logic [24:0]        o_instruction,
  output logic               o_run,
  input  logic               i_executing
);

  localparam logic [1:0] OP_WRITE   = 2'd0;
  localparam logic [1:0] OP_READ    = 2'd1;
  localparam logic [1:0] OP_EXECUTE = 2'd2;
  localparam logic [1:0] OP_ILLEGAL = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RD,
    S_RUN,
    S_SETTLE
  } state_t;

  state_t               state_q, state_d;
  logic [5:0]           reg_id_q;
  logic [31:0]          data_in_q;
  logic [24:0]          instr_q;
  logic [31:0]          rsp_data_q;
  logic                 rsp_valid_q;
  logic                 err_q;
  logic [STALL_W-1:0]   stall_cnt_q;

  logic                 cmd_ready;
  logic                 accept;
  logic                 stall;

  // Only an idle sequencer with a quiet engine may take a command.
  assign cmd_ready = (state_q == S_IDLE) && !i_executing;
  assign accept    = i_cmdValid && cmd_ready;
  assign stall     = i_cmdValid && !cmd_ready;

  // Next-state logic: each engine access is a single-cycle state; an execute
  // adds a SETTLE cycle so the engine's registered busy flag is seen before
  // IDLE evaluates readiness again.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (i_cmdOp)
            OP_WRITE:   state_d = S_WR;
            OP_READ:    state_d = S_RD;
            OP_EXECUTE: state_d = S_RUN;
            default:    state_d = S_IDLE;
          endcase
        end
      end
      S_WR:     state_d = S_IDLE;
      S_RD:     state_d = S_IDLE;
      S_RUN:    state_d = S_SETTLE;
      S_SETTLE: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Engine-facing fields are captured on accept only and held otherwise;
  // read data is captured at the end of the RD cycle and pulsed valid next.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      reg_id_q    <= '0;
      data_in_q   <= '0;
      instr_q     <= '0;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      if (accept && (i_cmdOp == OP_WRITE || i_cmdOp == OP_READ)) begin
        reg_id_q <= i_cmdReg;
      end
      if (accept && i_cmdOp == OP_WRITE) begin
        data_in_q <= i_cmdData;
      end
      if (accept && i_cmdOp == OP_EXECUTE) begin
        instr_q <= i_cmdInstr;
      end
      if (state_q == S_RD) begin
        rsp_data_q <= i_dataOut;
      end
      rsp_valid_q <= (state_q == S_RD);
      err_q       <= accept && (i_cmdOp == OP_ILLEGAL);
    end
  end

  // Saturating stall counter; clear wins over increment.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      stall_cnt_q <= '0;
    end else if (i_stallClr) begin
      stall_cnt_q <= '0;
    end else if (stall && (stall_cnt_q != {STALL_W{1'b1}})) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign o_cmdReady    = cmd_ready;
  assign o_cpuStall    = stall;
  assign o_rspValid    = rsp_valid_q;
  assign o_rspData     = rsp_data_q;
  assign o_errIllegal  = err_q;
  assign o_stallCount  = stall_cnt_q;
  assign o_regID       = reg_id_q;
  assign o_dataIn      = data_in_q;
  assign o_instruction = instr_q;
  assign o_writReg     = (state_q == S_WR);
  assign o_run         = (state_q == S_RUN);

endmodule

// File: tb/tb_gte_cop2_sequencer.sv
// Testbench for gte_cop2_sequencer: table of single register/illegal commands
// plus hand-written execute, saturation and reset-during-run sequences.
module tb_gte_cop2_sequencer;

  logic        i_clk;
  logic        i_rst;
  logic        i_cmdValid;
  logic        o_cmdReady;
  logic [1:0]  i_cmdOp;
  logic [5:0]  i_cmdReg;
  logic [31:0] i_cmdData;
  logic [24:0] i_cmdInstr;
  logic        o_rspValid;
  logic [31:0] o_rspData;
  logic        o_cpuStall;
  logic        o_errIllegal;
  logic        i_stallClr;
  logic [15:0] o_stallCount;
  logic [5:0]  o_regID;
  logic        o_writReg;
  logic [31:0] o_dataIn;
  logic [31:0] i_dataOut;
  logic [24:0] o_instruction;
  logic        o_run;
  logic        i_executing;

  gte_cop2_sequencer #(.STALL_W(16)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_cmdValid(i_cmdValid), .o_cmdReady(o_cmdReady),
    .i_cmdOp(i_cmdOp), .i_cmdReg(i_cmdReg), .i_cmdData(i_cmdData),
    .i_cmdInstr(i_cmdInstr),
    .o_rspValid(o_rspValid), .o_rspData(o_rspData),
    .o_cpuStall(o_cpuStall), .o_errIllegal(o_errIllegal),
    .i_stallClr(i_stallClr), .o_stallCount(o_stallCount),
    .o_regID(o_regID), .o_writReg(o_writReg), .o_dataIn(o_dataIn),
    .i_dataOut(i_dataOut), .o_instruction(o_instruction),
    .o_run(o_run), .i_executing(i_executing)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Engine model: register file with combinational read, busy for exec_len
  // cycles starting the cycle after run (not affected by sequencer reset).
  logic [31:0] eng_mem [64];
  logic        mem_init;
  logic        exec_force;
  int          exec_len = 0;
  int          busy_cnt = 0;

  always @(posedge i_clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++)
        eng_mem[i] <= (i == 40) ? 32'hCAFE0001 : 32'h10000000 + i;
    end else if (o_writReg) begin
      eng_mem[o_regID] <= o_dataIn;
    end
  end

  always @(posedge i_clk) begin
    if (o_run) busy_cnt <= exec_len;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end

  assign i_dataOut   = eng_mem[o_regID];
  assign i_executing = exec_force | (busy_cnt != 0);

  int checks = 0;
  int failures = 0;
  logic [5:0]  last_reg;
  logic [31:0] last_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [5:0]  rg;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [9];

  // Applies one command starting #1 after a posedge with the sequencer idle.
  task automatic run_vec(input vec_t v);
    check("ready_before_cmd", 32'(o_cmdReady), 32'd1);
    i_cmdValid = 1'b1;
    i_cmdOp    = v.op;
    i_cmdReg   = v.rg;
    i_cmdData  = v.data;
    i_cmdInstr = 25'h0;
    @(posedge i_clk); #1;
    // Scramble fields after accept; they must be ignored.
    i_cmdValid = 1'b0;
    i_cmdReg   = ~v.rg;
    i_cmdData  = ~v.data;
    case (v.op)
      2'd0: begin
        check("wr_strobe_n1", 32'(o_writReg), 32'd1);
        check("wr_regid_n1", 32'(o_regID), 32'(v.rg));
        check("wr_datain_n1", o_dataIn, v.data);
        check("wr_run_n1", 32'(o_run), 32'd0);
        @(posedge i_clk); #1;
        check("wr_strobe_n2", 32'(o_writReg), 32'd0);
        check("wr_ready_n2", 32'(o_cmdReady), 32'd1);
        last_reg  = v.rg;
        last_data = v.data;
      end
      2'd1: begin
        check("rd_strobe_n1", 32'(o_writReg), 32'd0);
        check("rd_regid_n1", 32'(o_regID), 32'(v.rg));
        check("rd_valid_n1", 32'(o_rspValid), 32'd0);
        @(posedge i_clk); #1;
        check("rd_valid_n2", 32'(o_rspValid), 32'd1);
        check("rd_data_n2", o_rspData, v.exp);
        check("rd_ready_n2", 32'(o_cmdReady), 32'd1);
        @(posedge i_clk); #1;
        check("rd_valid_n3", 32'(o_rspValid), 32'd0);
        check("rd_data_held_n3", o_rspData, v.exp);
        last_reg = v.rg;
      end
      default: begin
        check("ill_err_n1", 32'(o_errIllegal), 32'd1);
        check("ill_strobe_n1", 32'(o_writReg), 32'd0);
        check("ill_run_n1", 32'(o_run), 32'd0);
        check("ill_ready_n1", 32'(o_cmdReady), 32'd1);
        check("ill_regid_hold", 32'(o_regID), 32'(last_reg));
        check("ill_datain_hold", o_dataIn, last_data);
        @(posedge i_clk); #1;
        check("ill_err_n2", 32'(o_errIllegal), 32'd0);
      end
    endcase
  endtask

  initial begin
    int k;
    vecs[0] = '{2'd0, 6'd5,  32'h12345678, 32'h12345678};
    vecs[1] = '{2'd1, 6'd40, 32'h0,        32'hCAFE0001};
    vecs[2] = '{2'd1, 6'd5,  32'h0,        32'h12345678};
    vecs[3] = '{2'd3, 6'd7,  32'h55555555, 32'h0};
    vecs[4] = '{2'd0, 6'd63, 32'hDEADBEEF, 32'hDEADBEEF};
    vecs[5] = '{2'd1, 6'd63, 32'h0,        32'hDEADBEEF};
    vecs[6] = '{2'd0, 6'd0,  32'hFFFFFFFF, 32'hFFFFFFFF};
    vecs[7] = '{2'd1, 6'd0,  32'h0,        32'hFFFFFFFF};
    vecs[8] = '{2'd1, 6'd12, 32'h0,        32'h1000000C};

    i_rst = 1'b1; mem_init = 1'b1; exec_force = 1'b0;
    i_cmdValid = 1'b0; i_cmdOp = 2'd0; i_cmdReg = 6'd0; i_cmdData = 32'd0;
    i_cmdInstr = 25'd0; i_stallClr = 1'b0;
    last_reg = 6'd0; last_data = 32'd0;
    repeat (3) @(posedge i_clk);
    #1;
    i_rst = 1'b0; mem_init = 1'b0;

    // Reset values
    check("rst_writreg", 32'(o_writReg), 32'd0);
    check("rst_run", 32'(o_run), 32'd0);
    check("rst_rspvalid", 32'(o_rspValid), 32'd0);
    check("rst_err", 32'(o_errIllegal), 32'd0);
    check("rst_stallcnt", 32'(o_stallCount), 32'd0);
    check("rst_regid", 32'(o_regID), 32'd0);
    check("rst_datain", o_dataIn, 32'd0);
    check("rst_instr", 32'(o_instruction), 32'd0);
    check("rst_rspdata", o_rspData, 32'd0);
    check("rst_ready", 32'(o_cmdReady), 32'd1);

    for (int i = 0; i < 9; i++) run_vec(vecs[i]);
    check("no_stall_after_table", 32'(o_stallCount), 32'd0);

    // Execute with engine busy 20 cycles, read queued behind it
    exec_len = 20;
    i_cmdValid = 1'b1; i_cmdOp = 2'd2; i_cmdInstr = 25'h0180001;
    @(posedge i_clk); #1;                 // N+1
    check("ex_run_n1", 32'(o_run), 32'd1);
    check("ex_instr_n1", 32'(o_instruction), 32'h0180001);
    check("ex_strobe_n1", 32'(o_writReg), 32'd0);
    i_cmdOp = 2'd1; i_cmdReg = 6'd40; i_cmdInstr = 25'h1FFFFFF;
    check("ex_stall_n1", 32'(o_cpuStall), 32'd1);
    @(posedge i_clk); #1;                 // N+2
    check("ex_run_n2", 32'(o_run), 32'd0);
    check("ex_ready_settle", 32'(o_cmdReady), 32'd0);
    k = 2;
    while (!o_cmdReady && k < 200) begin
      @(posedge i_clk); #1;
      k++;
    end
    check("ex_read_accept_cycle", 32'(k), 32'd22);
    @(posedge i_clk); #1;                 // read in RD
    i_cmdValid = 1'b0;
    check("ex_stallcount", 32'(o_stallCount), 32'd21);
    check("ex_read_regid", 32'(o_regID), 32'd40);
    check("ex_instr_hold", 32'(o_instruction), 32'h0180001);
    @(posedge i_clk); #1;
    check("ex_read_valid", 32'(o_rspValid), 32'd1);
    check("ex_read_data", o_rspData, 32'hCAFE0001);
    last_reg = 6'd40;

    // Saturation of the stall counter, then clear during a stall
    i_stallClr = 1'b1;
    @(posedge i_clk); #1;
    i_stallClr = 1'b0;
    check("sat_clr_start", 32'(o_stallCount), 32'd0);
    exec_force = 1'b1; i_cmdValid = 1'b1; i_cmdOp = 2'd1;
    repeat (70000) @(posedge i_clk);
    #1;
    check("sat_value", 32'(o_stallCount), 32'h0000FFFF);
    i_stallClr = 1'b1;
    @(posedge i_clk); #1;
    check("sat_clr_prio", 32'(o_stallCount), 32'd0);
    i_stallClr = 1'b0;
    @(posedge i_clk); #1;
    check("sat_resume", 32'(o_stallCount), 32'd1);
    i_cmdValid = 1'b0; exec_force = 1'b0;
    @(posedge i_clk); #1;
    check("sat_ready_after", 32'(o_cmdReady), 32'd1);

    // Reset during RUN while engine stays busy 5 cycles
    exec_len = 5;
    i_cmdValid = 1'b1; i_cmdOp = 2'd2; i_cmdInstr = 25'h1ABCDEF;
    @(posedge i_clk); #1;                 // N+1, RUN
    i_cmdValid = 1'b0;
    check("rr_run_n1", 32'(o_run), 32'd1);
    i_rst = 1'b1;
    @(posedge i_clk); #1;                 // N+2
    i_rst = 1'b0;
    check("rr_run", 32'(o_run), 32'd0);
    check("rr_writreg", 32'(o_writReg), 32'd0);
    check("rr_rspvalid", 32'(o_rspValid), 32'd0);
    check("rr_err", 32'(o_errIllegal), 32'd0);
    check("rr_stallcnt", 32'(o_stallCount), 32'd0);
    check("rr_regid", 32'(o_regID), 32'd0);
    check("rr_datain", o_dataIn, 32'd0);
    check("rr_instr", 32'(o_instruction), 32'd0);
    check("rr_rspdata", o_rspData, 32'd0);
    check("rr_ready_busy", 32'(o_cmdReady), 32'd0);
    k = 2;
    while (!o_cmdReady && k < 200) begin
      @(posedge i_clk); #1;
      k++;
    end
    check("rr_ready_cycle", 32'(k), 32'd7);
    last_reg = 6'd0; last_data = 32'd0;
    run_vec(vecs[3]);
    run_vec(vecs[8]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gte_cop2_sequencer.md
# gte_cop2_sequencer

CPU-facing COP2 command sequencer sitting directly upstream of the GTE engine. It accepts MTC2/CTC2 writes, MFC2/CFC2 reads and COP2 execute commands from the CPU pipeline one at a time. It serialises them onto the engine's register port (regID/write/dataIn/dataOut) and run/instruction port. It interlocks every command against the engine's executing flag and counts CPU stall cycles.

## Interface
- STALL_W, 16, width of the saturating stall counter
- i_clk  in  1  clock, all logic on rising edge
- i_rst  in  1  reset, synchronous, active-high
- i_cmdValid  in  1  CPU command present
- o_cmdReady  out  1  command accepted this cycle when i_cmdValid & o_cmdReady
- i_cmdOp  in  2  0=write reg, 1=read reg, 2=execute, 3=illegal
- i_cmdReg  in  6  GTE register index (data 0-31, control 32-63)
- i_cmdData  in  32  write data
- i_cmdInstr  in  25  COP2 instruction field (execute only)
- o_rspValid  out  1  one-cycle pulse, read data valid
- o_rspData  out  32  read data, held until next read response
- o_cpuStall  out  1  i_cmdValid & !o_cmdReady
- o_errIllegal  out  1  one-cycle pulse on accepting op 3
- i_stallClr  in  1  clear stall counter
- o_stallCount  out  STALL_W  saturating count of cycles with o_cpuStall=1
- o_regID  out  6  to engine regID
- o_writReg  out  1  to engine write strobe
- o_dataIn  out  32  to engine write data
- i_dataOut  in  32  from engine read data, combinational from o_regID
- o_instruction  out  25  to engine instruction
- o_run  out  1  to engine run
- i_executing  in  1  from engine busy flag

## Operation
- States: IDLE, WR, RD, RUN, SETTLE.
- o_cmdReady = (state==IDLE) & !i_executing.
- IDLE + accept:
  - op0 -> WR; o_regID/o_dataIn loaded from command.
  - op1 -> RD; o_regID loaded.
  - op2 -> RUN; o_instruction loaded.
  - op3 -> stays IDLE, o_errIllegal pulse next cycle, no engine access.
- WR: o_writReg=1 for exactly this cycle -> IDLE.
- RD: o_writReg=0; i_dataOut registered into o_rspData at end of cycle; o_rspValid=1 next cycle -> IDLE.
- RUN: o_run=1 for exactly this cycle -> SETTLE.
- SETTLE: one guard cycle, lasting until the engine's registered executing flag is visible -> IDLE. IDLE then holds further commands until i_executing=0.
- Reads and writes are also blocked while i_executing=1. No register access overlaps an execution.
- o_regID, o_dataIn and o_instruction hold their last value outside active states. o_writReg and o_run are 0 outside WR and RUN.
- Stall counter:
  - +1 per cycle with o_cpuStall=1, saturates at all-ones.
  - i_stallClr has priority over increment and forces 0.
- No response backpressure: CPU must take o_rspValid when it pulses.

## Timing
- Reset: state=IDLE. o_writReg, o_run, o_rspValid, o_errIllegal and o_stallCount are 0. o_regID, o_dataIn, o_instruction and o_rspData are 0.
- Reset mid-operation aborts the sequencer only, not the engine. If i_executing remains 1 after reset, o_cmdReady stays 0 until it falls.
- Accept at cycle N:
  - Write: o_writReg at N+1; next accept possible at N+2.
  - Read: o_regID valid at N+1; o_rspValid/o_rspData at N+2; next accept possible at N+2.
  - Execute: o_run at N+1, SETTLE at N+2; earliest next accept is N+3, and only if i_executing=0.
- Illegal: o_errIllegal at N+1; next accept possible at N+1.
- Throughput: one read or write per 2 cycles.
- o_cmdReady is combinational from state and i_executing.
- Command fields are sampled only on the accept cycle; later changes on CPU inputs are ignored.

## Test plan
- Reset, then write op0 reg 5 data 0x12345678 -> o_writReg=1 exactly one cycle at N+1 with o_regID=5, o_dataIn=0x12345678; o_cmdReady high again at N+2.
- Read op1 reg 40 with engine model returning 0xCAFE0001 -> o_rspValid at N+2, o_rspData=0xCAFE0001, held after pulse.
- Execute 0x0180001 with engine busy for 20 cycles, then a queued read -> o_run one cycle at N+1; read accepted only after i_executing falls; o_stallCount equals the stall cycles (approx. 21 incl. SETTLE).
- i_executing=1 with i_cmdValid held for 70000 cycles -> o_stallCount saturates at 0xFFFF; i_stallClr same cycle as a stall -> 0.
- op3 -> o_errIllegal pulse at N+1, no o_writReg/o_run activity; o_cmdReady high at N+1.
- Assert i_rst during RUN while engine stays busy 5 cycles -> all outputs at reset values next cycle; o_cmdReady 0 until i_executing=0.
